// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT cipher datapath: state type and the
// pLayer bit-index maps used to build the permutation wiring.
package present_pkg;

  localparam int STATE_W = 64;

  typedef logic [STATE_W-1:0] state_t;

  // Destination index of source bit i under the forward pLayer of a w-bit state.
  function automatic int p_idx(input int i, input int w = STATE_W);
    if (i == w - 1) return w - 1;
    return (i * (w / 4)) % (w - 1);
  endfunction

  // Destination index of source bit i under the inverse pLayer of a w-bit state.
  function automatic int p_inv_idx(input int i, input int w = STATE_W);
    if (i == w - 1) return w - 1;
    return (i * 4) % (w - 1);
  endfunction

endpackage

// File: rtl/present_p_perm.sv
// Purely combinational pLayer wiring (forward map; inverse map and select
// added when PLAYER_INVERSE_EN is defined).
module present_p_perm
  import present_pkg::*;
#(
  parameter int WIDTH = STATE_W
) (
  input  logic [WIDTH-1:0] original,
`ifdef PLAYER_INVERSE_EN
  input  logic             inverse,
`endif
  output logic [WIDTH-1:0] permuted
);

  logic [WIDTH-1:0] fwd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fwd
    assign fwd[p_idx(i, WIDTH)] = original[i];
  end

`ifdef PLAYER_INVERSE_EN
  logic [WIDTH-1:0] inv;

  for (genvar j = 0; j < WIDTH; j++) begin : g_inv
    assign inv[p_inv_idx(j, WIDTH)] = original[j];
  end

  assign permuted = inverse ? inv : fwd;
`else
  assign permuted = fwd;
`endif

endmodule

// File: rtl/present_p_layer.sv
// PRESENT pLayer with a zero-latency combinational output and a one-cycle
// registered copy plus valid flag. Optional inverse map: PLAYER_INVERSE_EN.
module present_p_layer
  import present_pkg::*;
#(
  parameter int WIDTH = STATE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] original,
`ifdef PLAYER_INVERSE_EN
  input  logic             inverse,
`endif
  output logic [WIDTH-1:0] permuted,
  input  logic             in_valid,
  output logic [WIDTH-1:0] permuted_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  present_p_perm #(
    .WIDTH(WIDTH)
  ) u_perm (
    .original(original),
`ifdef PLAYER_INVERSE_EN
    .inverse (inverse),
`endif
    .permuted(permuted)
  );

  // The registered copy reuses the combinational result, so the inverse
  // select is naturally sampled together with in_valid.
  always_comb begin
    data_d  = data_q;
    valid_d = in_valid;
    if (in_valid) data_d = permuted;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign permuted_q = data_q;
  assign out_valid  = valid_q;

endmodule

// File: tb/tb_present_p_layer.sv
// Self-checking bench for present_p_layer: directed vectors, one-hot walk and
// a randomized stream compared against an index-arithmetic reference model.
module tb_present_p_layer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] original;
  logic [63:0] permuted;
  logic        inValid;
  logic [63:0] permutedQ;
  logic        outValid;
`ifdef PLAYER_INVERSE_EN
  logic        inverse;
`endif

  int checks = 0;
  int errors = 0;

  logic [63:0] expQ;
  logic        expV;
  logic [63:0] outs[64];

  always #5 clk = ~clk;

  present_p_layer #(
    .WIDTH(64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .original  (original),
`ifdef PLAYER_INVERSE_EN
    .inverse   (inverse),
`endif
    .permuted  (permuted),
    .in_valid  (inValid),
    .permuted_q(permutedQ),
    .out_valid (outValid)
  );

  // Reference: move each bit by the index rule, 16*i mod 63 forward, 4*i mod 63 inverse.
  function automatic logic [63:0] refPerm(input logic [63:0] w, input bit inv);
    logic [63:0] r;
    int d;
    r = '0;
    for (int i = 0; i < 63; i++) begin
      d = inv ? (i * 4) % 63 : (i * 16) % 63;
      r[d] = w[i];
    end
    r[63] = w[63];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] w, input logic v);
    original = w;
    inValid  = v;
    #1;
    checkOutput("comb", permuted, refPerm(w, 1'b0));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] w;
    logic        v;
    int          dups;
    int          dest;

    reset    = 1'b0;
    original = '0;
    inValid  = 1'b0;
`ifdef PLAYER_INVERSE_EN
    inverse  = 1'b0;
`endif
    #1;
    checkOutput("rst_q", permutedQ, 64'h0);
    checkOutput("rst_v", 64'(outValid), 64'h0);

    // Directed vectors, applied while reset is held to show the wiring ignores it.
    applyStimulus(64'h0000000000000000, 1'b0);
    checkOutput("zero", permuted, 64'h0000000000000000);
    applyStimulus(64'hFFFFFFFFFFFFFFFF, 1'b0);
    checkOutput("ones", permuted, 64'hFFFFFFFFFFFFFFFF);
    applyStimulus(64'h0000000000000002, 1'b0);
    checkOutput("bit1", permuted, 64'h0000000000010000);
    applyStimulus(64'h0000000000000010, 1'b0);
    checkOutput("bit4", permuted, 64'h0000000000000002);
    applyStimulus(64'h4000000000000000, 1'b0);
    checkOutput("bit62", permuted, 64'h0000800000000000);
    applyStimulus(64'h8000000000000000, 1'b0);
    checkOutput("bit63", permuted, 64'h8000000000000000);

    for (int i = 0; i < 64; i++) begin
      original = 64'd1 << i;
      #1;
      dest = (i == 63) ? 63 : (i * 16) % 63;
      checkOutput($sformatf("onehot%0d", i), permuted, 64'd1 << dest);
      outs[i] = permuted;
    end
    dups = 0;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < i; j++)
        if (outs[i] === outs[j]) dups++;
    checkOutput("onehot_unique", 64'(dups), 64'h0);
    checkOutput("rst_hold_q", permutedQ, 64'h0);

    // Registered path, directed.
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(64'h0000000000000002, 1'b1);
    @(negedge clk);
    checkOutput("reg_q", permutedQ, 64'h0000000000010000);
    checkOutput("reg_v", 64'(outValid), 64'h1);
    applyStimulus({$urandom, $urandom}, 1'b0);
    @(negedge clk);
    checkOutput("hold_q", permutedQ, 64'h0000000000010000);
    checkOutput("hold_v", 64'(outValid), 64'h0);
    expQ = 64'h0000000000010000;
    expV = 1'b0;

    // Randomized stream with a mid-stream asynchronous reset.
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      checkOutput("pipe_q", permutedQ, expQ);
      checkOutput("pipe_v", 64'(outValid), 64'(expV));
      reset = 1'b1;
      w = {$urandom, $urandom};
      v = ($urandom_range(0, 3) != 0);
      applyStimulus(w, v);
      checkOutput("popcnt", 64'($countones(permuted)), 64'($countones(w)));
      if (v) expQ = refPerm(w, 1'b0);
      expV = v;
      if (c == 150) begin
        inValid = 1'b1;
        reset   = 1'b0;
        #1;
        checkOutput("async_rst_q", permutedQ, 64'h0);
        checkOutput("async_rst_v", 64'(outValid), 64'h0);
        applyStimulus({$urandom, $urandom}, 1'b1);
        expQ = 64'h0;
        expV = 1'b0;
      end
    end

`ifdef PLAYER_INVERSE_EN
    @(negedge clk);
    inValid  = 1'b0;
    inverse  = 1'b1;
    original = 64'h0000000000010000;
    #1;
    checkOutput("inv_bit16", permuted, 64'h0000000000000002);
    for (int k = 0; k < 40; k++) begin
      w = {$urandom, $urandom};
      inverse  = 1'b0;
      original = w;
      #1;
      original = permuted;
      inverse  = 1'b1;
      #1;
      checkOutput("roundtrip", permuted, w);
      checkOutput("inv_model", permuted, refPerm(original, 1'b1));
    end
    @(negedge clk);
    w        = {$urandom, $urandom};
    original = w;
    inverse  = 1'b1;
    inValid  = 1'b1;
    @(negedge clk);
    checkOutput("inv_reg_q", permutedQ, refPerm(w, 1'b1));
    checkOutput("inv_reg_v", 64'(outValid), 64'h1);
    inverse = 1'b0;
    inValid = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
